// File: rtl/theta_row_sched.sv
// Anubis theta layer, one 4-byte row per clock, with a single shared row of x2/x4 multipliers.
// Optional THETA_KEYADD_EN fuses the sigma key addition into each written row.
module theta_row_sched #(
    parameter int unsigned N_ROWS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*N_ROWS-1:0]  state_in,
`ifdef THETA_KEYADD_EN
    input  logic [32*N_ROWS-1:0]  key_in,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*N_ROWS-1:0]  state_out,
    output logic                  busy
);

    localparam int unsigned W  = 32 * N_ROWS;
    localparam int unsigned CW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        st;
    logic [CW-1:0] cnt;
    logic [W-1:0]  work;
    logic [31:0]   row_a;
    logic [31:0]   row_b;
    logic [31:0]   row_k;
    logic [31:0]   row_w;
    logic [7:0]    prod [4][4];

`ifdef THETA_KEYADD_EN
    logic [W-1:0]  key_q;
`endif

    // Multiply by x modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1d : 8'h00);
    endfunction

    // Row mux: the only place cnt steers the datapath.
    always_comb begin
        row_a = '0;
        row_k = '0;
        for (int r = 0; r < int'(N_ROWS); r++) begin
            if (CW'(r) == cnt) begin
                row_a = work[W-1-32*r -: 32];
`ifdef THETA_KEYADD_EN
                row_k = key_q[W-1-32*r -: 32];
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod[i][0] = row_a[31-8*i -: 8];
            prod[i][1] = xt(prod[i][0]);
            prod[i][2] = xt(prod[i][1]);
            prod[i][3] = prod[i][1] ^ prod[i][2];
        end
        row_b = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                row_b[31-8*j -: 8] = row_b[31-8*j -: 8] ^ prod[i][i ^ j];
            end
        end
        row_w = row_b ^ row_k;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= StIdle;
            cnt       <= '0;
            work      <= '0;
            state_out <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef THETA_KEYADD_EN
            key_q     <= '0;
`endif
        end else begin
            unique case (st)
                StIdle: begin
                    if (in_valid) begin
                        work     <= state_in;
`ifdef THETA_KEYADD_EN
                        key_q    <= key_in;
`endif
                        cnt      <= '0;
                        st       <= StBusy;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StBusy: begin
                    for (int r = 0; r < int'(N_ROWS); r++) begin
                        if (CW'(r) == cnt) begin
                            state_out[W-1-32*r -: 32] <= row_w;
                        end
                    end
                    if (cnt == CW'(N_ROWS - 1)) begin
                        st        <= StDone;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        st        <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: st <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/theta_row_sched.md
Name: theta_row_sched

Overview:
- Sequences the Anubis theta (MDS) linear layer over the 128-bit cipher state, one 4-byte row per clock.
- Shares a single row's worth of GF(2^8) constant-multiplier lookups (x2 and x4 per byte, poly 0x11d) across all rows instead of instantiating them per state byte.
- Sits between the gamma (S-box) and pi/sigma stages of the round datapath.
- Uses a valid/ready handshake on both sides.

Parameters:
- N_ROWS, 4, number of 4-byte state rows processed; legal range 1..4; state width = 32*N_ROWS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  state_in holds a valid state
- in_ready  output  1  block can accept a state (high only in IDLE)
- state_in  input  32*N_ROWS  state; row r occupies bits [32*N_ROWS-1-32r -: 32]; within a row, byte 0 is the MSB
- out_valid  output  1  state_out holds theta(state_in)
- out_ready  input  1  consumer accepts state_out
- state_out  output  32*N_ROWS  result, same byte layout as state_in
- busy  output  1  high in BUSY

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-operation):
  - FSM goes to IDLE, row counter goes to 0.
  - state_out=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
  - Any partial result is discarded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid=1, latch state_in into the working register, clear the row counter, go to BUSY (capture edge E0).
  - BUSY: in_ready=0, busy=1. On each edge, row[cnt] of the result register is written and cnt increments. When cnt=N_ROWS-1 is written, go to DONE. The last row is written at edge E(N_ROWS).
  - DONE: out_valid=1, state_out held stable. When out_ready=1, go to IDLE and clear out_valid. in_ready stays 0 during DONE, so a new input is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid is high N_ROWS cycles after the capture edge (4 for default). Throughput is one state per N_ROWS+2 cycles with out_ready tied high.
- Row arithmetic, for a = 4 input bytes of the current row:
  - b[j] = XOR over i=0..3 of a[i]·h[i^j], with h = (01,02,04,06) in GF(2^8), poly x^8+x^4+x^3+x^2+1.
  - a·06 = (a·02) XOR (a·04). Only 4 x2 and 4 x4 lookups exist, shared by all rows via a row mux driven by cnt.
- Theta is an involution: the same block serves encryption and decryption, and no mode input exists.
- state_out bits of rows not yet written during BUSY are don't-care. Only the DONE value is architectural.
- in_valid while not in IDLE is ignored. The producer must hold in_valid and state_in until in_ready.
- out_ready outside DONE has no effect.

Optional Feature:
- Macro THETA_KEYADD_EN.
- When defined:
  - Extra input key_in (32*N_ROWS) is latched with state_in at the capture edge.
  - Each result row is XORed with the matching key row before writing, so state_out = theta(state_in) XOR key_in (sigma fused).
  - Latency is unchanged.
- When undefined: the port is absent and state_out = theta(state_in).

Test Plan:
- Basic row: state_in row0 = 01000000, other rows 0 → state_out row0 = 01020406, others 00000000; out_valid 4 cycles after capture.
- Reduction: row0 = 80000000 → 801d3a27. Row1 = 00010000 → row1 = 02010604.
- Fixed point: state_in all 0xff → state_out all 0xff (1^2^4^6 = 1).
- Involution: random state through twice → original. Back-to-back with out_ready=1 → in_ready reasserts one cycle after the out handshake, never during DONE.
- Stall and reset: hold out_ready=0 for 10 cycles → out_valid and state_out stable. Assert rst during BUSY at cnt=2 → next cycle IDLE, out_valid=0, state_out=0, in_ready=1; a following input completes correctly.
- THETA_KEYADD_EN: state row0 = 01000000, key row0 = ffffffff → row0 = fefdfbf9.
